// File: rtl/lcd_page_scheduler.sv
// Selects one of NPAGES debug line pairs for the two-line LCD. Page advances come from a
// debounced key or an auto-rotate timer and are applied only at LCD frame boundaries.
module lcd_page_scheduler #(
    parameter int unsigned NPAGES          = 8,
    parameter int unsigned NBITS_LCD       = 64,
    parameter int unsigned HOLD_CYCLES     = 50_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NPAGES*NBITS_LCD-1:0]   page_a,
    input  logic [NPAGES*NBITS_LCD-1:0]   page_b,
    input  logic                          key_next,
    input  logic                          auto_en,
    input  logic                          frame_done,
    output logic [NBITS_LCD-1:0]          lcd_a,
    output logic [NBITS_LCD-1:0]          lcd_b,
    output logic [$clog2(NPAGES)-1:0]     page,
    output logic                          snap
);

    localparam int unsigned PW = $clog2(NPAGES);
    localparam int unsigned TW = $clog2(HOLD_CYCLES);
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);

    logic                 sync1_q, sync2_q;
    logic                 deb_q, deb_d;
    logic [DW-1:0]        cnt_q, cnt_d;
    logic [TW-1:0]        tim_q, tim_d;
    logic                 pending_q, pending_d;
    logic [PW-1:0]        page_q, page_d;
    logic [NBITS_LCD-1:0] lcd_a_q, lcd_a_d, lcd_b_q, lcd_b_d;
    logic                 snap_q, snap_d;
    logic                 press_event, timer_event;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            deb_q     <= 1'b1;
            cnt_q     <= '0;
            tim_q     <= '0;
            pending_q <= 1'b0;
            page_q    <= '0;
            lcd_a_q   <= '0;
            lcd_b_q   <= '0;
            snap_q    <= 1'b0;
        end else begin
            sync1_q   <= key_next;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            cnt_q     <= cnt_d;
            tim_q     <= tim_d;
            pending_q <= pending_d;
            page_q    <= page_d;
            lcd_a_q   <= lcd_a_d;
            lcd_b_q   <= lcd_b_d;
            snap_q    <= snap_d;
        end
    end

    always_comb begin
        deb_d     = deb_q;
        cnt_d     = '0;
        tim_d     = tim_q;
        page_d    = page_q;
        lcd_a_d   = lcd_a_q;
        lcd_b_d   = lcd_b_q;
        snap_d    = frame_done;

        // Count consecutive clocks of disagreement; any agreement restarts the count.
        if (sync2_q != deb_q) begin
            if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + DW'(1);
            end
        end
        press_event = deb_q & ~deb_d;

        timer_event = auto_en && (tim_q == TW'(HOLD_CYCLES - 1));
        if (!auto_en || press_event || timer_event) begin
            tim_d = '0;
        end else begin
            tim_d = tim_q + TW'(1);
        end

        pending_d = (pending_q & ~frame_done) | press_event | timer_event;

        if (frame_done) begin
            if (pending_q) begin
                page_d = (page_q == PW'(NPAGES - 1)) ? '0 : page_q + PW'(1);
            end
            lcd_a_d = page_a[page_d*NBITS_LCD +: NBITS_LCD];
            lcd_b_d = page_b[page_d*NBITS_LCD +: NBITS_LCD];
        end
    end

    assign lcd_a = lcd_a_q;
    assign lcd_b = lcd_b_q;
    assign page  = page_q;
    assign snap  = snap_q;

endmodule

// File: tb/tb_lcd_page_scheduler.sv
// Self-checking bench for lcd_page_scheduler: directed scenarios plus random stimulus,
// all compared against a cycle-level behavioural reference model.
module tb_lcd_page_scheduler;

    localparam int unsigned NP = 4;
    localparam int unsigned NB = 64;
    localparam int unsigned HC = 10;
    localparam int unsigned DC = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP*NB-1:0]  page_a, page_b;
    logic              key_next, auto_en, frame_done;
    logic [NB-1:0]     lcd_a, lcd_b;
    logic [1:0]        page;
    logic              snap;

    logic [NB-1:0]     pa [NP];
    logic [NB-1:0]     pb [NP];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic          m_s1, m_s2, m_deb, m_pend, m_snap;
    logic          hist[$];
    int            m_tim, m_page;
    logic [NB-1:0] m_a, m_b;

    lcd_page_scheduler #(
        .NPAGES(NP), .NBITS_LCD(NB), .HOLD_CYCLES(HC), .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk(clk), .reset(reset), .page_a(page_a), .page_b(page_b),
        .key_next(key_next), .auto_en(auto_en), .frame_done(frame_done),
        .lcd_a(lcd_a), .lcd_b(lcd_b), .page(page), .snap(snap)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            page_a[p*NB +: NB] = pa[p];
            page_b[p*NB +: NB] = pb[p];
        end
    end

    task automatic check(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 1'b1; m_s2 = 1'b1; m_deb = 1'b1; m_pend = 1'b0; m_snap = 1'b0;
        hist.delete();
        m_tim = 0; m_page = 0; m_a = '0; m_b = '0;
    endtask

    // One clock edge of the reference model, using the inputs present at that edge.
    task automatic model_step();
        logic press, tev, all_diff;
        press = 1'b0;
        // Debounced level follows the synchronized key once the last DC samples all disagree.
        hist.push_back(m_s2);
        if (hist.size() > DC) void'(hist.pop_front());
        all_diff = (hist.size() == DC);
        foreach (hist[i]) if (hist[i] == m_deb) all_diff = 1'b0;
        if (all_diff) begin
            press = (m_deb == 1'b1);
            m_deb = ~m_deb;
        end
        m_s2 = m_s1;
        m_s1 = key_next;
        tev = auto_en && (m_tim == HC - 1);
        m_tim = (!auto_en || press || tev) ? 0 : m_tim + 1;
        if (frame_done) begin
            if (m_pend) m_page = (m_page + 1) % NP;
            m_a = pa[m_page];
            m_b = pb[m_page];
        end
        m_snap = frame_done;
        m_pend = (m_pend && !frame_done) || press || tev;
    endtask

    task automatic cmp_all();
        check("lcd_a", lcd_a, m_a);
        check("lcd_b", lcd_b, m_b);
        check("page", NB'(page), NB'(m_page));
        check("snap", NB'(snap), NB'(m_snap));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        model_step();
        cmp_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic frame();
        frame_done = 1'b1;
        cyc();
        frame_done = 1'b0;
    endtask

    // Asynchronous assertion between edges, release well before the next edge.
    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        key_next = 1'b1;
        frame_done = 1'b0;
        #1;
        model_reset();
        cmp_all();
        check("rst_lcd_a", lcd_a, '0);
        check("rst_page", NB'(page), '0);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        for (int p = 0; p < NP; p++) begin
            pa[p] = NB'(p);
            pb[p] = NB'(32'h100 + p);
        end
        reset = 1'b1; key_next = 1'b1; auto_en = 1'b0; frame_done = 1'b0;
        do_reset();

        // Plain frame on page 0
        run(4);
        frame();
        check("t1_page", NB'(page), '0);
        check("t1_lcd_a", lcd_a, '0);
        check("t1_lcd_b", lcd_b, 64'h100);
        check("t1_snap", NB'(snap), 1);
        cyc();
        check("t1_snap_low", NB'(snap), 0);

        // Debounced press advances; short bounce does not
        key_next = 1'b0; run(6);
        key_next = 1'b1; run(1);
        frame();
        check("t2_page", NB'(page), 1);
        check("t2_lcd_a", lcd_a, 1);
        run(6);
        key_next = 1'b0; run(2);
        key_next = 1'b1; run(8);
        frame();
        check("t2_bounce_page", NB'(page), 1);

        // Auto-rotate with wrap
        do_reset();
        auto_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            frame_done = (i % 4 == 3);
            cyc();
        end
        frame_done = 1'b0;
        check("t3_page", NB'(page), 3);
        auto_en = 1'b0;
        frame();
        check("t3_wrap", NB'(page), 0);

        // Several presses between frames collapse to one advance
        do_reset();
        for (int k = 0; k < 3; k++) begin
            key_next = 1'b0; run(6);
            key_next = 1'b1; run(6);
        end
        frame();
        check("t4_page", NB'(page), 1);
        run(2);
        frame();
        check("t4_page_again", NB'(page), 1);

        // Live data is captured only at frame boundaries
        pa[1] = 64'hDEAD;
        run(3);
        check("t6_lcd_hold", lcd_a, 1);
        frame();
        check("t6_lcd_new", lcd_a, 64'hDEAD);
        pa[1] = 64'd1;

        // Timer event coincident with frame_done stays pending
        do_reset();
        auto_en = 1'b1;
        run(9);
        frame();
        check("t5_same_cycle", NB'(page), 0);
        run(2);
        frame();
        check("t5_next_frame", NB'(page), 1);
        auto_en = 1'b0;

        // Reset mid-debounce discards the press
        key_next = 1'b0; run(3);
        do_reset();
        run(10);
        frame();
        check("t6_no_spurious", NB'(page), 0);

        // Random stimulus
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) key_next = ~key_next;
            if ($urandom_range(0, 49) == 0) auto_en = ~auto_en;
            frame_done = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 19) == 0) pa[$urandom_range(0, NP - 1)] = {$urandom, $urandom};
            if ($urandom_range(0, 19) == 0) pb[$urandom_range(0, NP - 1)] = {$urandom, $urandom};
            cyc();
            if ($urandom_range(0, 499) == 0) do_reset();
        end
        frame_done = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
